// File: rtl/ula_pkg.sv
// rtl/ula_pkg.sv - funct codes, FSM states and helpers shared by the multicycle ALU
package ula_pkg;

  localparam logic [5:0] F_MFHI  = 6'd16;
  localparam logic [5:0] F_MFLO  = 6'd18;
  localparam logic [5:0] F_MULT  = 6'd24;
  localparam logic [5:0] F_MULTU = 6'd25;
  localparam logic [5:0] F_DIV   = 6'd26;
  localparam logic [5:0] F_DIVU  = 6'd27;
  localparam logic [5:0] F_ADD   = 6'd32;
  localparam logic [5:0] F_ADDU  = 6'd33;
  localparam logic [5:0] F_SUB   = 6'd34;
  localparam logic [5:0] F_SUBU  = 6'd35;
  localparam logic [5:0] F_AND   = 6'd36;
  localparam logic [5:0] F_OR    = 6'd37;
  localparam logic [5:0] F_XOR   = 6'd38;
  localparam logic [5:0] F_NOR   = 6'd39;
  localparam logic [5:0] F_SLT   = 6'd42;
  localparam logic [5:0] F_SLTU  = 6'd43;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_DIV,
    S_FIX,
    S_DONE
  } state_t;

  function automatic logic is_muldiv(input logic [5:0] funct);
    return (funct == F_MULT) || (funct == F_MULTU) || (funct == F_DIV) || (funct == F_DIVU);
  endfunction

endpackage

// File: rtl/ula_muldiv.sv
// rtl/ula_muldiv.sv - iterative shift-add multiplier / restoring divider on operand magnitudes
module ula_muldiv #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             go,
  input  logic             signed_op,
  input  logic             is_div,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             fin,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH:0]     r_mcand;
  logic [CW-1:0]      r_cnt;
  logic               r_busy, r_is_div, r_neg_q, r_neg_r;

  logic [WIDTH:0]     w_a_mag, w_b_mag, w_msum, w_shift;
  logic [WIDTH-1:0]   w_sub, w_quo, w_rem;
  logic               w_ge;
  logic [2*WIDTH-1:0] w_mul_next, w_div_next, w_prod;

  // WIDTH+1 bits so the most-negative operand has a representable magnitude
  assign w_a_mag = (signed_op && a[WIDTH-1]) ? -{a[WIDTH-1], a} : {1'b0, a};
  assign w_b_mag = (signed_op && b[WIDTH-1]) ? -{b[WIDTH-1], b} : {1'b0, b};

  assign w_msum     = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + r_mcand;
  assign w_mul_next = r_acc[0] ? {w_msum, r_acc[WIDTH-1:1]}
                               : {1'b0, r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1:1]};

  // Remainder lives in the upper half, dividend/quotient bits shift through the lower half
  assign w_shift    = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_ge       = (w_shift >= r_mcand);
  assign w_sub      = WIDTH'(w_shift - r_mcand);
  assign w_div_next = w_ge ? {w_sub, r_acc[WIDTH-2:0], 1'b1}
                           : {w_shift[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  assign w_prod = r_neg_q ? -r_acc : r_acc;
  assign w_quo  = r_neg_q ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_rem  = r_neg_r ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  assign busy = r_busy;
  assign fin  = r_busy && (r_cnt == CW'(WIDTH - 1));
  assign hi   = r_is_div ? w_rem : w_prod[2*WIDTH-1:WIDTH];
  assign lo   = r_is_div ? w_quo : w_prod[WIDTH-1:0];

  always_ff @(posedge clock) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
      r_is_div <= 1'b0;
      r_neg_q  <= 1'b0;
      r_neg_r  <= 1'b0;
    end else if (go) begin
      r_busy   <= 1'b1;
      r_cnt    <= '0;
      r_is_div <= is_div;
      r_neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]);
      r_neg_r  <= signed_op && a[WIDTH-1];
      r_mcand  <= is_div ? w_b_mag : w_a_mag;
      r_acc    <= is_div ? {{WIDTH{1'b0}}, w_a_mag[WIDTH-1:0]}
                         : {{WIDTH{1'b0}}, w_b_mag[WIDTH-1:0]};
    end else if (r_busy) begin
      r_acc <= r_is_div ? w_div_next : w_mul_next;
      r_cnt <= r_cnt + CW'(1);
      if (fin) r_busy <= 1'b0;
    end
  end

endmodule

// File: rtl/ula_multicycle.sv
// rtl/ula_multicycle.sv - registered MIPS R-type ALU with multi-cycle MULT/DIV into HI/LO
module ula_multicycle
  import ula_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       operation,
  input  logic [WIDTH-1:0] inputA,
  input  logic [WIDTH-1:0] inputB,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             overflow,
  output logic             illegal
);

  state_t           r_state, w_next;
  logic [WIDTH-1:0] r_result, r_hi, r_lo;
  logic             r_overflow, r_illegal;

  logic             w_accept, w_is_mul, w_is_div, w_divzero, w_go, w_signed;
  logic             w_md_busy, w_md_fin;
  logic [WIDTH-1:0] w_md_hi, w_md_lo;
  logic [WIDTH-1:0] w_sum, w_diff, w_sc_result;
  logic             w_sc_overflow, w_sc_illegal;

  assign w_accept  = start && (r_state == S_IDLE);
  assign w_is_mul  = (operation == F_MULT) || (operation == F_MULTU);
  assign w_is_div  = (operation == F_DIV) || (operation == F_DIVU);
  assign w_divzero = w_is_div && (inputB == '0);
  assign w_go      = w_accept && is_muldiv(operation) && !w_divzero;
  assign w_signed  = (operation == F_MULT) || (operation == F_DIV);

  ula_muldiv #(.WIDTH(WIDTH)) u_muldiv (
    .clock     (clock),
    .reset     (reset),
    .go        (w_go),
    .signed_op (w_signed),
    .is_div    (w_is_div),
    .a         (inputA),
    .b         (inputB),
    .busy      (w_md_busy),
    .fin       (w_md_fin),
    .hi        (w_md_hi),
    .lo        (w_md_lo)
  );

  always_comb begin
    w_sum         = inputA + inputB;
    w_diff        = inputA - inputB;
    w_sc_result   = '0;
    w_sc_overflow = 1'b0;
    w_sc_illegal  = 1'b0;
    case (operation)
      F_ADD: begin
        w_sc_result   = w_sum;
        w_sc_overflow = (inputA[WIDTH-1] == inputB[WIDTH-1]) && (w_sum[WIDTH-1] != inputA[WIDTH-1]);
      end
      F_ADDU: w_sc_result = w_sum;
      F_SUB: begin
        w_sc_result   = w_diff;
        w_sc_overflow = (inputA[WIDTH-1] != inputB[WIDTH-1]) && (w_diff[WIDTH-1] != inputA[WIDTH-1]);
      end
      F_SUBU: w_sc_result = w_diff;
      F_AND:  w_sc_result = inputA & inputB;
      F_OR:   w_sc_result = inputA | inputB;
      F_XOR:  w_sc_result = inputA ^ inputB;
      F_NOR:  w_sc_result = ~(inputA | inputB);
      F_SLT:  w_sc_result = {{(WIDTH-1){1'b0}}, ($signed(inputA) < $signed(inputB))};
      F_SLTU: w_sc_result = {{(WIDTH-1){1'b0}}, (inputA < inputB)};
      F_MFHI: w_sc_result = r_hi;
      F_MFLO: w_sc_result = r_lo;
      default: w_sc_illegal = 1'b1;
    endcase
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (w_go && w_is_mul)      w_next = S_MUL;
          else if (w_go && w_is_div) w_next = S_DIV;
          else                       w_next = S_DONE;
        end
      end
      S_MUL, S_DIV: begin
        // Engine idle while we wait would mean a lost operation; recover to IDLE
        if (w_md_fin)        w_next = S_FIX;
        else if (!w_md_busy) w_next = S_IDLE;
      end
      S_FIX:   w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_result   <= '0;
      r_hi       <= '0;
      r_lo       <= '0;
      r_overflow <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_accept && !w_go) begin
        if (w_divzero) begin
          r_hi       <= inputA;
          r_lo       <= '1;
          r_overflow <= 1'b0;
          r_illegal  <= 1'b0;
        end else begin
          r_result   <= w_sc_result;
          r_overflow <= w_sc_overflow;
          r_illegal  <= w_sc_illegal;
        end
      end
      if (r_state == S_FIX) begin
        r_hi       <= w_md_hi;
        r_lo       <= w_md_lo;
        r_overflow <= 1'b0;
        r_illegal  <= 1'b0;
      end
    end
  end

  assign ready    = (r_state == S_IDLE);
  assign done     = (r_state == S_DONE);
  assign result   = r_result;
  assign hi       = r_hi;
  assign lo       = r_lo;
  assign overflow = r_overflow;
  assign illegal  = r_illegal;

endmodule
